ili9341_8080_rx: RTL

- Responder end of the 8080-I MCU parallel bus used by the team's ILI9341 driver: a display-side receiver that decodes the bus into commands and pixel writes.
- Samples CSX/WRX/DCX/D[7:0] on the system clock, tracks the column/page window set by CASET (0x2A) and PASET (0x2B), and assembles RGB565 pixels after RAMWR (0x2C) or RAMWRC (0x3C).
- Emits one linear frame-buffer address per pixel.
- Used as a bench display model and as an FPGA-side sink for capturing or mirroring frames.

---
 rtl/ili9341_8080_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ili9341_8080_rx.sv
// Display-side receiver for the 8080-I parallel bus: decodes commands, tracks the
// CASET/PASET window and turns RAMWR/RAMWRC byte pairs into addressed RGB565 pixels.
module ili9341_8080_rx #(
    parameter int unsigned COLS      = 240,
    parameter int unsigned ROWS      = 320,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tftParallelPort,
    input  logic        tftChipSelect,
    input  logic        tftWriteEnable,
    input  logic        tftDataCmd,
    input  logic        tftReset,
    output logic        cmdValid,
    output logic [7:0]  cmdByte,
    output logic        dataValid,
    output logic [7:0]  dataByte,
    output logic        pixelValid,
    output logic [15:0] pixelData,
    output logic [16:0] pixelAddr
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned POS_W  = 16;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned IDX_W  = 3;

    localparam logic [DATA_W-1:0] CMD_CASET  = 8'h2A;
    localparam logic [DATA_W-1:0] CMD_PASET  = 8'h2B;
    localparam logic [DATA_W-1:0] CMD_RAMWR  = 8'h2C;
    localparam logic [DATA_W-1:0] CMD_RAMWRC = 8'h3C;

    localparam logic [POS_W-1:0] EC_RESET = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] EP_RESET = POS_W'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, OTHER} state_t;

    // Two-flop synchronisers for every bus input
    logic              csMeta, csS, csPrev;
    logic              wrMeta, wrS, wrPrev;
    logic              dcMeta, dcS;
    logic              resxMeta, resxS;
    logic [DATA_W-1:0] dMeta, dS;

    always_ff @(posedge clk) begin
        if (reset) begin
            csMeta   <= 1'b1;
            csS      <= 1'b1;
            csPrev   <= 1'b1;
            wrMeta   <= 1'b1;
            wrS      <= 1'b1;
            wrPrev   <= 1'b1;
            dcMeta   <= 1'b1;
            dcS      <= 1'b1;
            resxMeta <= 1'b1;
            resxS    <= 1'b1;
            dMeta    <= '0;
            dS       <= '0;
        end else begin
            csMeta   <= tftChipSelect;
            csS      <= csMeta;
            csPrev   <= csS;
            wrMeta   <= tftWriteEnable;
            wrS      <= wrMeta;
            wrPrev   <= wrS;
            dcMeta   <= tftDataCmd;
            dcS      <= dcMeta;
            resxMeta <= tftReset;
            resxS    <= resxMeta;
            dMeta    <= tftParallelPort;
            dS       <= dMeta;
        end
    end

    logic strobe, cmdStrobe, dataStrobe, csRise;
    assign strobe     = wrS & ~wrPrev & ~csS;
    assign cmdStrobe  = strobe & ~dcS;
    assign dataStrobe = strobe & dcS;
    assign csRise     = csS & ~csPrev;

    state_t             state, stateNext;
    logic [POS_W-1:0]   sc, ec, sp, ep, col, page;
    logic [POS_W-1:0]   scNext, ecNext, spNext, epNext, colNext, pageNext;
    logic [IDX_W-1:0]   paramIdx, idxNext;
    logic               phase, phaseNext;
    logic [DATA_W-1:0]  held, heldNext;
    logic               cmdValidNext, dataValidNext, pixelValidNext;
    logic [DATA_W-1:0]  cmdByteNext, dataByteNext;
    logic [PIX_W-1:0]   pixelDataNext, pixelWord;
    logic [ADDR_W-1:0]  pixelAddrNext;
    logic [31:0]        addrWide;
    logic               inRange;

    assign pixelWord = MSB_FIRST ? {held, dS} : {dS, held};
    assign addrWide  = 32'(page) * COLS + 32'(col);
    assign inRange   = (32'(col) < COLS) && (32'(page) < ROWS);

    // Next-state and output decode; a command strobe always wins over pixel assembly
    always_comb begin
        stateNext      = state;
        scNext         = sc;
        ecNext         = ec;
        spNext         = sp;
        epNext         = ep;
        colNext        = col;
        pageNext       = page;
        idxNext        = paramIdx;
        phaseNext      = phase;
        heldNext       = held;
        cmdValidNext   = 1'b0;
        cmdByteNext    = cmdByte;
        dataValidNext  = 1'b0;
        dataByteNext   = dataByte;
        pixelValidNext = 1'b0;
        pixelDataNext  = pixelData;
        pixelAddrNext  = pixelAddr;

        if (cmdStrobe) begin
            cmdValidNext = 1'b1;
            cmdByteNext  = dS;
            idxNext      = '0;
            phaseNext    = 1'b0;
            case (dS)
                CMD_CASET:  stateNext = CASET;
                CMD_PASET:  stateNext = PASET;
                CMD_RAMWR: begin
                    stateNext = RAMWR;
                    colNext   = sc;
                    pageNext  = sp;
                end
                CMD_RAMWRC: stateNext = RAMWR;
                default:    stateNext = OTHER;
            endcase
        end else if (dataStrobe) begin
            dataValidNext = 1'b1;
            dataByteNext  = dS;
            case (state)
                CASET: begin
                    if (paramIdx < 3'd4) begin
                        case (paramIdx[1:0])
                            2'd0:    scNext = {dS, sc[7:0]};
                            2'd1:    scNext = {sc[15:8], dS};
                            2'd2:    ecNext = {dS, ec[7:0]};
                            default: ecNext = {ec[15:8], dS};
                        endcase
                        idxNext = paramIdx + 3'd1;
                    end
                end
                PASET: begin
                    if (paramIdx < 3'd4) begin
                        case (paramIdx[1:0])
                            2'd0:    spNext = {dS, sp[7:0]};
                            2'd1:    spNext = {sp[15:8], dS};
                            2'd2:    epNext = {dS, ep[7:0]};
                            default: epNext = {ep[15:8], dS};
                        endcase
                        idxNext = paramIdx + 3'd1;
                    end
                end
                RAMWR: begin
                    if (!phase) begin
                        heldNext  = dS;
                        phaseNext = 1'b1;
                    end else begin
                        phaseNext = 1'b0;
                        if (inRange) begin
                            pixelValidNext = 1'b1;
                            pixelDataNext  = pixelWord;
                            pixelAddrNext  = ADDR_W'(addrWide);
                        end
                        // Window scan; an inverted window simply wraps through 16 bits
                        if (col == ec) begin
                            colNext  = sc;
                            pageNext = (page == ep) ? sp : page + 16'd1;
                        end else begin
                            colNext = col + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end else if (csRise) begin
            phaseNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !resxS) begin
            state      <= IDLE;
            sc         <= '0;
            ec         <= EC_RESET;
            sp         <= '0;
            ep         <= EP_RESET;
            col        <= '0;
            page       <= '0;
            paramIdx   <= '0;
            phase      <= 1'b0;
            held       <= '0;
            cmdValid   <= 1'b0;
            cmdByte    <= '0;
            dataValid  <= 1'b0;
            dataByte   <= '0;
            pixelValid <= 1'b0;
            pixelData  <= '0;
            pixelAddr  <= '0;
        end else begin
            state      <= stateNext;
            sc         <= scNext;
            ec         <= ecNext;
            sp         <= spNext;
            ep         <= epNext;
            col        <= colNext;
            page       <= pageNext;
            paramIdx   <= idxNext;
            phase      <= phaseNext;
            held       <= heldNext;
            cmdValid   <= cmdValidNext;
            cmdByte    <= cmdByteNext;
            dataValid  <= dataValidNext;
            dataByte   <= dataByteNext;
            pixelValid <= pixelValidNext;
            pixelData  <= pixelDataNext;
            pixelAddr  <= pixelAddrNext;
        end
    end

endmodule
